// File: rtl/rc5_enc_sched.sv
// Round-robin front end that time-shares one rc5_enc_16bit core among NUM_REQ requesters.
// Each transaction: grant, load the core under reset, run it under a watchdog, return a tagged response.
module rc5_enc_sched #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 15,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [16*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [15:0]           rsp_data,
  output logic [IDW-1:0]        rsp_id,
  output logic                  rsp_err,
  output logic                  busy,
  output logic                  core_rst_n,
  output logic                  core_start,
  output logic [15:0]           core_p,
  input  logic [15:0]           core_c,
  input  logic                  core_done
);
  localparam int DATA_W = 16;
  // Wide enough to hold TIMEOUT-1, the last RUN cycle before the watchdog fires.
  localparam int WDW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, RESP} state_t;

  state_t              state;
  logic [IDW-1:0]      rr_ptr;
  logic [WDW-1:0]      wd_cnt;
  logic                run_en;
  logic                grant_ok;
  logic [IDW-1:0]      grant_idx;
  logic [DATA_W-1:0]   req_word [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_word
    assign req_word[i] = req_data[i*DATA_W +: DATA_W];
  end

  // First valid requester at or after rr_ptr, searching upward with wrap.
  always_comb begin
    int cand;
    logic [IDW-1:0] cand_idx;
    cand      = 0;
    cand_idx  = '0;
    grant_ok  = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand     = (int'(rr_ptr) + k) % NUM_REQ;
      cand_idx = IDW'(cand);
      if (!grant_ok && req_valid[cand_idx]) begin
        grant_ok  = 1'b1;
        grant_idx = cand_idx;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == IDLE && !reset && grant_ok) req_ready[grant_idx] = 1'b1;
  end

  assign busy       = (state != IDLE);
  assign core_rst_n = run_en;
  assign core_start = run_en;

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      wd_cnt    <= '0;
      run_en    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
      rsp_err   <= 1'b0;
      core_p    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_ok) begin
            core_p <= req_word[grant_idx];
            rsp_id <= grant_idx;
            rr_ptr <= (int'(grant_idx) == NUM_REQ-1) ? '0 : grant_idx + 1'b1;
            state  <= LOAD;
          end
        end
        LOAD: begin
          wd_cnt <= '0;
          run_en <= 1'b1;
          state  <= RUN;
        end
        RUN: begin
          wd_cnt <= wd_cnt + 1'b1;
          // A done arriving on the watchdog's last cycle still counts as success.
          if (core_done) begin
            rsp_data  <= core_c;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            run_en    <= 1'b0;
            state     <= RESP;
          end else if (wd_cnt == WDW'(TIMEOUT-1)) begin
            rsp_data  <= '0;
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
            run_en    <= 1'b0;
            state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rc5_enc_sched.sv
// Directed bench for rc5_enc_sched with a behavioural core model (done after a set number of run edges).
module tb_rc5_enc_sched;
  logic        clock;
  logic        reset;
  logic [3:0]  req_valid;
  logic [63:0] req_data;
  logic [3:0]  req_ready;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic [1:0]  rsp_id;
  logic        rsp_err;
  logic        busy;
  logic        core_rst_n;
  logic        core_start;
  logic [15:0] core_p;
  logic [15:0] core_c;
  logic        core_done;

  int n_chk  = 0;
  int n_fail = 0;
  int done_at = 5;
  int mcnt;
  logic [15:0] mp;

  rc5_enc_sched #(.NUM_REQ(4), .TIMEOUT(15)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_id(rsp_id), .rsp_err(rsp_err), .busy(busy),
    .core_rst_n(core_rst_n), .core_start(core_start), .core_p(core_p),
    .core_c(core_c), .core_done(core_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Core model: latches p while held in reset, raises done so it is seen on the done_at-th run edge.
  always_ff @(posedge clock) begin
    if (!core_rst_n) begin
      mcnt      <= 0;
      core_done <= 1'b0;
      mp        <= core_p;
    end else if (core_start) begin
      mcnt <= mcnt + 1;
      if (mcnt == done_at - 2) core_done <= 1'b1;
    end
  end
  assign core_c = mp ^ 16'hA5A5;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_rsp(input int limit, output int cyc);
    cyc = 0;
    @(negedge clock);
    while (!rsp_valid && cyc < limit) begin
      @(negedge clock);
      cyc++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got 0 expected 1");
    $fatal(1, "bench timed out");
  end

  int rr_order[5] = '{0, 1, 2, 3, 0};
  logic [15:0] rr_c[4] = '{16'hA5A5, 16'hB4B4, 16'h8787, 16'h9696};

  initial begin
    int n_acc, n_rsp, last, n;
    reset = 1'b1; req_valid = '0; req_data = '0; rsp_ready = 1'b0;
    repeat (3) next_cyc();
    @(negedge clock);
    check("rst_busy", busy, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_core_rst_n", core_rst_n, 0);
    check("rst_core_start", core_start, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_rsp_id", rsp_id, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_core_p", core_p, 0);
    next_cyc();
    req_valid = 4'b1111;
    @(negedge clock);
    check("rst_gates_ready", req_ready, 0);

    // Round robin with all requesters held valid.
    req_data = {16'h3333, 16'h2222, 16'h1111, 16'h0000};
    rsp_ready = 1'b1;
    next_cyc();
    reset = 1'b0;
    n_acc = 0; n_rsp = 0; last = 0;
    for (int cyc = 0; cyc < 33; cyc++) begin
      @(negedge clock);
      if (req_ready != 0) begin
        if (n_acc < 5) check("rr_grant", req_ready, 32'd1 << rr_order[n_acc]);
        else check("rr_extra_grant", req_ready, 0);
        if (n_acc > 0) check("rr_gap", cyc - last, 8);
        last = cyc;
        n_acc++;
      end
      if (rsp_valid && n_rsp < 5) begin
        check("rr_id", rsp_id, rr_order[n_rsp]);
        check("rr_data", rsp_data, rr_c[rr_order[n_rsp]]);
        check("rr_err", rsp_err, 0);
        n_rsp++;
      end
      next_cyc();
      if (n_acc == 5) req_valid = '0;
    end
    check("rr_accepts", n_acc, 5);
    check("rr_rsps", n_rsp, 4);
    wait_rsp(20, n);
    check("rr_last_valid", rsp_valid, 1);
    check("rr_last_id", rsp_id, 0);
    check("rr_last_data", rsp_data, 16'hA5A5);

    // Single request with latency checks; input data changes after the accept.
    next_cyc();
    req_valid = 4'b0100;
    req_data[32 +: 16] = 16'h1234;
    @(negedge clock);
    check("one_ready", req_ready, 4'b0100);
    next_cyc();
    req_valid = '0;
    req_data[32 +: 16] = 16'hDEAD;
    @(negedge clock);
    check("one_load_p", core_p, 16'h1234);
    check("one_load_rst", core_rst_n, 0);
    check("one_load_ready", req_ready, 0);
    check("one_load_busy", busy, 1);
    for (int c = 2; c <= 6; c++) begin
      next_cyc();
      @(negedge clock);
      if (c == 2) begin
        check("one_run_rst", core_rst_n, 1);
        check("one_run_start", core_start, 1);
        check("one_run_p", core_p, 16'h1234);
      end
      check("one_run_nov", rsp_valid, 0);
    end
    next_cyc();
    @(negedge clock);
    check("one_rsp_valid", rsp_valid, 1);
    check("one_rsp_data", rsp_data, 16'hB791);
    check("one_rsp_id", rsp_id, 2);
    check("one_rsp_err", rsp_err, 0);
    check("one_rsp_core_rst", core_rst_n, 0);
    next_cyc();
    @(negedge clock);
    check("one_done_valid", rsp_valid, 0);
    check("one_done_busy", busy, 0);

    // Back-pressure on the response port with a new request pending.
    rsp_ready = 1'b0;
    next_cyc();
    req_valid = 4'b0010;
    req_data[16 +: 16] = 16'hFFFF;
    @(negedge clock);
    check("bp_grant", req_ready, 4'b0010);
    next_cyc();
    req_valid = '0;
    wait_rsp(20, n);
    check("bp_first_valid", rsp_valid, 1);
    for (int i = 0; i < 10; i++) begin
      next_cyc();
      if (i == 0) begin
        req_valid = 4'b0001;
        req_data[0 +: 16] = 16'h0F0F;
      end
      @(negedge clock);
      check("bp_valid", rsp_valid, 1);
      check("bp_data", rsp_data, 16'h5A5A);
      check("bp_id", rsp_id, 1);
      check("bp_no_ready", req_ready, 0);
      check("bp_core_rst", core_rst_n, 0);
    end
    next_cyc();
    rsp_ready = 1'b1;
    @(negedge clock);
    check("bp_hold_valid", rsp_valid, 1);
    next_cyc();
    @(negedge clock);
    check("bp_released", rsp_valid, 0);
    check("bp_next_grant", req_ready, 4'b0001);
    next_cyc();
    req_valid = '0;
    wait_rsp(20, n);
    check("bp2_valid", rsp_valid, 1);
    check("bp2_data", rsp_data, 16'hAAAA);
    check("bp2_id", rsp_id, 0);

    // Core never finishes: watchdog error response.
    done_at = 99;
    next_cyc();
    req_valid = 4'b1000;
    req_data[48 +: 16] = 16'h4321;
    @(negedge clock);
    check("to_grant", req_ready, 4'b1000);
    next_cyc();
    req_valid = '0;
    wait_rsp(40, n);
    check("to_latency", n, 16);
    check("to_valid", rsp_valid, 1);
    check("to_err", rsp_err, 1);
    check("to_data", rsp_data, 0);
    check("to_id", rsp_id, 3);

    // Done on the watchdog's final cycle wins over the timeout.
    done_at = 15;
    next_cyc();
    req_valid = 4'b0001;
    req_data[0 +: 16] = 16'h5555;
    @(negedge clock);
    check("dw_grant", req_ready, 4'b0001);
    next_cyc();
    req_valid = '0;
    wait_rsp(40, n);
    check("dw_latency", n, 16);
    check("dw_err", rsp_err, 0);
    check("dw_data", rsp_data, 16'hF0F0);
    done_at = 5;

    // Normal request after the error, then pointer wrap from 3 to 0.
    next_cyc();
    req_valid = 4'b1000;
    req_data[48 +: 16] = 16'h00FF;
    @(negedge clock);
    check("wr_grant3", req_ready, 4'b1000);
    next_cyc();
    req_valid = '0;
    wait_rsp(20, n);
    check("wr_latency3", n, 6);
    check("wr_data3", rsp_data, 16'hA55A);
    check("wr_err3", rsp_err, 0);
    next_cyc();
    req_valid = 4'b1001;
    req_data[0 +: 16] = 16'hABCD;
    @(negedge clock);
    check("wr_grant0", req_ready, 4'b0001);
    next_cyc();
    req_valid = '0;
    wait_rsp(20, n);
    check("wr_data0", rsp_data, 16'h0E68);
    check("wr_id0", rsp_id, 0);

    // Reset during RUN abandons the transaction and clears the pointer.
    next_cyc();
    req_valid = 4'b0010;
    req_data[16 +: 16] = 16'h2468;
    @(negedge clock);
    check("mr_grant", req_ready, 4'b0010);
    next_cyc();
    next_cyc();
    @(negedge clock);
    check("mr_in_run", core_rst_n, 1);
    next_cyc();
    reset = 1'b1;
    @(negedge clock);
    next_cyc();
    @(negedge clock);
    check("mr_busy", busy, 0);
    check("mr_core_rst", core_rst_n, 0);
    check("mr_core_start", core_start, 0);
    check("mr_rsp_valid", rsp_valid, 0);
    check("mr_req_ready", req_ready, 0);
    check("mr_rsp_data", rsp_data, 0);
    check("mr_core_p", core_p, 0);
    next_cyc();
    reset = 1'b0;
    req_valid = 4'b1010;
    @(negedge clock);
    check("mr_regrant", req_ready, 4'b0010);
    check("mr_no_rsp", rsp_valid, 0);
    next_cyc();
    req_valid = '0;
    wait_rsp(20, n);
    check("mr_data", rsp_data, 16'h81CD);
    check("mr_id", rsp_id, 1);
    check("mr_err", rsp_err, 0);
    next_cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
